// File: rtl/flag_pkg.sv
// Shared definitions for the flag bank: flag bit indices, default sizing and the flag vector type.
package flag_pkg;

   localparam int unsigned FLAG_Z = 0;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_N = 2;
   localparam int unsigned FLAG_V = 3;

   localparam int unsigned DEF_NFLAGS = 4;
   localparam int unsigned DEF_DEPTH  = 2;

   typedef logic [DEF_NFLAGS-1:0] flags_t;

endpackage

// File: rtl/flag_stack.sv
// Parametrised LIFO for saving and restoring flag vectors; reports full/empty and a
// one-cycle error pulse for overflow, underflow or simultaneous push/pop.
module flag_stack
   import flag_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_NFLAGS,
   parameter int unsigned DEPTH = DEF_DEPTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty,
   output logic             full,
   output logic             push_ok,
   output logic             pop_ok,
   output logic             err
);

   localparam int unsigned PW = $clog2(DEPTH + 1);

   logic [PW-1:0]    ptr;
   logic [WIDTH-1:0] mem [DEPTH];

   assign empty   = (ptr == '0);
   assign full    = (ptr == PW'(DEPTH));
   assign push_ok = push & ~pop & ~full;
   assign pop_ok  = pop & ~push & ~empty;
   assign err     = (push & pop) | (push & ~pop & full) | (pop & ~push & empty);

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= '0;
      end else if (push_ok) begin
         ptr <= ptr + 1'b1;
      end else if (pop_ok) begin
         ptr <= ptr - 1'b1;
      end
   end

   // Entry contents are don't-care after reset, so storage carries no reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (push_ok && ptr == PW'(i)) begin
            mem[i] <= din;
         end
      end
   end

   always_comb begin
      rd_data = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (ptr == PW'(i + 1)) begin
            rd_data = mem[i];
         end
      end
   end

endmodule

// File: rtl/flag_bank.sv
// Status-flag register with masked update, direct write and a shadow stack.
// Define FLAG_BANK_FWD_EN to expose the combinational next flag value on f_fwd.
module flag_bank
   import flag_pkg::*;
#(
   parameter int unsigned              NFLAGS  = DEF_NFLAGS,
   parameter int unsigned              DEPTH   = DEF_DEPTH,
   parameter logic [NFLAGS-1:0]        RST_VAL = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NFLAGS-1:0] alu_flags,
   input  logic [NFLAGS-1:0] upd_mask,
   input  logic              wr_en,
   input  logic [NFLAGS-1:0] wr_data,
   input  logic              save,
   input  logic              restore,
   input  logic              err_clr,
   output logic [NFLAGS-1:0] f_out,
   output logic              stk_empty,
   output logic              stk_full,
   output logic              stk_err
`ifdef FLAG_BANK_FWD_EN
   ,
   output logic [NFLAGS-1:0] f_fwd
`endif
);

   logic [NFLAGS-1:0] f_next;
   logic [NFLAGS-1:0] stk_top;
   logic              push_ok;
   logic              pop_ok;
   logic              stk_err_evt;

   flag_stack #(
      .WIDTH (NFLAGS),
      .DEPTH (DEPTH)
   ) u_stack (
      .clk     (clk),
      .rst     (rst),
      .push    (save),
      .pop     (restore),
      .din     (f_out),
      .rd_data (stk_top),
      .empty   (stk_empty),
      .full    (stk_full),
      .push_ok (push_ok),
      .pop_ok  (pop_ok),
      .err     (stk_err_evt)
   );

   // push_ok is consumed inside the stack; the flag mux only cares about a valid pop.
   always_comb begin
      f_next = f_out;
      if (pop_ok) begin
         f_next = stk_top;
      end else if (wr_en) begin
         f_next = wr_data;
      end else begin
         f_next = (f_out & ~upd_mask) | (alu_flags & upd_mask);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         f_out   <= RST_VAL;
         stk_err <= 1'b0;
      end else begin
         f_out <= f_next;
         if (stk_err_evt) begin
            stk_err <= 1'b1;
         end else if (err_clr) begin
            stk_err <= 1'b0;
         end
      end
   end

`ifdef FLAG_BANK_FWD_EN
   assign f_fwd = rst ? RST_VAL : f_next;
`endif

endmodule

// File: tb/tb_flag_bank.sv
// Self-checking bench for flag_bank: directed scenarios plus randomized traffic against a
// queue-based reference model.
module tb_flag_bank;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] alu_flags;
   logic [3:0] upd_mask;
   logic       wr_en;
   logic [3:0] wr_data;
   logic       save;
   logic       restore;
   logic       err_clr;
   logic [3:0] f_out;
   logic       stk_empty;
   logic       stk_full;
   logic       stk_err;
`ifdef FLAG_BANK_FWD_EN
   logic [3:0] f_fwd;
`endif

   int tests_run = 0;
   int tests_failed = 0;

   // Reference model state
   logic [3:0] m_f;
   logic [3:0] m_stk[$];
   logic       m_err;

   flag_bank dut (
      .clk       (clk),
      .rst       (rst),
      .alu_flags (alu_flags),
      .upd_mask  (upd_mask),
      .wr_en     (wr_en),
      .wr_data   (wr_data),
      .save      (save),
      .restore   (restore),
      .err_clr   (err_clr),
      .f_out     (f_out),
      .stk_empty (stk_empty),
      .stk_full  (stk_full),
      .stk_err   (stk_err)
`ifdef FLAG_BANK_FWD_EN
      ,
      .f_fwd     (f_fwd)
`endif
   );

   always #5 clk = ~clk;

   task automatic idle();
      rst = 0; alu_flags = 0; upd_mask = 0; wr_en = 0; wr_data = 0;
      save = 0; restore = 0; err_clr = 0;
   endtask

   task automatic model_step();
      logic [3:0] nf;
      bit         err;
      if (rst) begin
         m_f = 4'b0000;
         m_stk.delete();
         m_err = 0;
      end else begin
         err = 0;
         nf = wr_en ? wr_data : ((m_f & ~upd_mask) | (alu_flags & upd_mask));
         if (save && restore) begin
            err = 1;
         end else if (save) begin
            if (m_stk.size() < 2) m_stk.push_back(m_f);
            else err = 1;
         end else if (restore) begin
            if (m_stk.size() > 0) nf = m_stk.pop_back();
            else err = 1;
         end
         m_f = nf;
         if (err) m_err = 1;
         else if (err_clr) m_err = 0;
      end
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [6:0] model_vec();
      return {m_f, m_stk.size() == 0, m_stk.size() == 2, m_err};
   endfunction

   task automatic test_reset();
      idle(); rst = 1; save = 1; wr_en = 1; wr_data = 4'hF;
      cycle(); idle();
      tests_run++;
      if ({f_out, stk_empty, stk_full, stk_err} !== {4'b0000, 1'b1, 1'b0, 1'b0}) begin
         tests_failed++;
         $display("FAIL reset: got f=%b e=%b f=%b err=%b, want f=0000 e=1 f=0 err=0",
                  f_out, stk_empty, stk_full, stk_err);
      end
   endtask

   task automatic test_mask();
      idle(); alu_flags = 4'b1111; upd_mask = 4'b0101;
      cycle(); idle();
      tests_run++;
      if (f_out !== 4'b0101) begin
         tests_failed++; $display("FAIL masked_update: got %b want 0101", f_out);
      end
      cycle();
      tests_run++;
      if (f_out !== 4'b0101) begin
         tests_failed++; $display("FAIL hold: got %b want 0101", f_out);
      end
   endtask

   task automatic test_write();
      idle(); wr_en = 1; wr_data = 4'b1010; upd_mask = 4'b1111; alu_flags = 4'b0001;
      cycle(); idle();
      tests_run++;
      if (f_out !== 4'b1010) begin
         tests_failed++; $display("FAIL write_beats_mask: got %b want 1010", f_out);
      end
   endtask

   task automatic test_save_restore();
      idle(); wr_en = 1; wr_data = 4'b0011; cycle();
      idle(); save = 1; upd_mask = 4'b1111; alu_flags = 4'b1100; cycle(); idle();
      tests_run++;
      if ({f_out, stk_empty} !== {4'b1100, 1'b0}) begin
         tests_failed++;
         $display("FAIL save_update: got f=%b e=%b want f=1100 e=0", f_out, stk_empty);
      end
      restore = 1; wr_en = 1; wr_data = 4'b1111; cycle(); idle();
      tests_run++;
      if ({f_out, stk_empty, stk_err} !== {4'b0011, 1'b1, 1'b0}) begin
         tests_failed++;
         $display("FAIL restore: got f=%b e=%b err=%b want f=0011 e=1 err=0",
                  f_out, stk_empty, stk_err);
      end
   endtask

   task automatic test_overflow();
      idle(); wr_en = 1; wr_data = 4'b0001; cycle();
      idle(); save = 1; wr_en = 1; wr_data = 4'b0010; cycle();
      wr_data = 4'b0100; cycle();
      tests_run++;
      if ({stk_full, stk_err} !== 2'b10) begin
         tests_failed++;
         $display("FAIL full_after_two: got full=%b err=%b want 1 0", stk_full, stk_err);
      end
      // Overflow coinciding with err_clr: the error must win.
      wr_data = 4'b1000; err_clr = 1; cycle(); idle();
      tests_run++;
      if ({f_out, stk_full, stk_err} !== {4'b1000, 1'b1, 1'b1}) begin
         tests_failed++;
         $display("FAIL overflow: got f=%b full=%b err=%b want f=1000 full=1 err=1",
                  f_out, stk_full, stk_err);
      end
      err_clr = 1; cycle(); idle();
      tests_run++;
      if (stk_err !== 1'b0) begin
         tests_failed++; $display("FAIL err_clr: got %b want 0", stk_err);
      end
      restore = 1; cycle();
      tests_run++;
      if ({f_out, stk_full} !== {4'b0010, 1'b0}) begin
         tests_failed++; $display("FAIL pop_after_overflow: got %b want 0010", f_out);
      end
      cycle(); idle();
      tests_run++;
      if ({f_out, stk_empty} !== {4'b0001, 1'b1}) begin
         tests_failed++; $display("FAIL pop_bottom: got %b e=%b want 0001 e=1", f_out, stk_empty);
      end
   endtask

   task automatic test_underflow_conflict();
      idle(); wr_en = 1; wr_data = 4'b0000; cycle();
      idle(); restore = 1; upd_mask = 4'b0001; alu_flags = 4'b0001; cycle(); idle();
      tests_run++;
      if ({f_out, stk_empty, stk_err} !== {4'b0001, 1'b1, 1'b1}) begin
         tests_failed++;
         $display("FAIL underflow: got f=%b e=%b err=%b want f=0001 e=1 err=1",
                  f_out, stk_empty, stk_err);
      end
      err_clr = 1; cycle(); idle();
      save = 1; wr_en = 1; wr_data = 4'b0110; cycle(); idle();
      save = 1; restore = 1; cycle(); idle();
      tests_run++;
      if ({f_out, stk_empty, stk_full, stk_err} !== {4'b0110, 1'b0, 1'b0, 1'b1}) begin
         tests_failed++;
         $display("FAIL conflict: got f=%b e=%b full=%b err=%b want 0110 0 0 1",
                  f_out, stk_empty, stk_full, stk_err);
      end
      restore = 1; cycle(); idle();
      tests_run++;
      if ({f_out, stk_empty} !== {4'b0001, 1'b1}) begin
         tests_failed++; $display("FAIL conflict_ptr: got %b e=%b want 0001 e=1", f_out, stk_empty);
      end
   endtask

   task automatic test_reset_mid_stack();
      idle(); err_clr = 1; save = 1; wr_en = 1; wr_data = 4'b0111; cycle();
      idle(); save = 1; cycle(); idle();
      rst = 1; restore = 1; cycle(); idle();
      tests_run++;
      if ({f_out, stk_empty, stk_full, stk_err} !== {4'b0000, 1'b1, 1'b0, 1'b0}) begin
         tests_failed++;
         $display("FAIL reset_mid_stack: got f=%b e=%b full=%b err=%b want 0000 1 0 0",
                  f_out, stk_empty, stk_full, stk_err);
      end
   endtask

   task automatic test_random();
      int errs = 0;
      idle(); rst = 1; cycle();
      for (int n = 0; n < 400; n++) begin
         rst       = ($urandom_range(0, 49) == 0);
         alu_flags = 4'($urandom);
         upd_mask  = 4'($urandom);
         wr_en     = ($urandom_range(0, 3) == 0);
         wr_data   = 4'($urandom);
         save      = ($urandom_range(0, 2) == 0);
         restore   = ($urandom_range(0, 2) == 0);
         err_clr   = ($urandom_range(0, 3) == 0);
         cycle();
         tests_run++;
         if ({f_out, stk_empty, stk_full, stk_err} !== model_vec()) begin
            tests_failed++;
            if (errs < 10) begin
               $display("FAIL random[%0d]: got f=%b e=%b full=%b err=%b want %b", n,
                        f_out, stk_empty, stk_full, stk_err, model_vec());
            end
            errs++;
         end
      end
      idle();
   endtask

   initial begin
      idle();
      m_f = 4'bxxxx;
      m_err = 0;
      test_reset();
      test_mask();
      test_write();
      test_save_restore();
      test_overflow();
      test_underflow_conflict();
      test_reset_mid_stack();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
